// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: opcode width and encoding.
package pc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD   = 3'd0,
    OP_INC    = 3'd1,
    OP_JUMP   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } pc_op_e;

endpackage

// File: rtl/return_stack.sv
// LIFO return-address storage with registered occupancy count.
// Callers must never push when full or pop when empty; gating lives upstream.
module return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetB,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SP_W-1:0]  sp_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign sp_m1  = sp - SP_W'(1);
  assign wr_idx = sp[IDX_W-1:0];
  assign rd_idx = sp_m1[IDX_W-1:0];
  assign top    = mem[rd_idx];
  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);

  // Occupancy counter; the only stack state that reset touches.
  always_ff @(posedge clk) begin
    if (!resetB)   sp <= '0;
    else if (push) sp <= sp + SP_W'(1);
    else if (pop)  sp <= sp_m1;
  end

  // Entry storage is never cleared; stale entries sit above sp and are unreadable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_return_stack.sv
// Program counter with increment, jump, signed relative branch and CALL/RET
// through an integrated return-address stack. Stack misuse sets a sticky fault.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                       clk,
  input  logic                       resetB,
  input  logic [OP_W-1:0]            op,
  input  logic [WIDTH-1:0]           dbus,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stackEmpty,
  output logic                       stackFull,
  output logic                       fault
);

  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] top;
  logic             push;
  logic             pop;
  logic             fault_set;

  // Two's-complement add wraps naturally modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] branch_target(input logic [WIDTH-1:0] base,
                                                     input logic [WIDTH-1:0] offs);
    logic signed [WIDTH-1:0] s_base;
    logic signed [WIDTH-1:0] s_offs;
    logic signed [WIDTH-1:0] s_sum;
    s_base = signed'(base);
    s_offs = signed'(offs);
    s_sum  = s_base + s_offs;
    return unsigned'(s_sum);
  endfunction

  assign pc_inc = pc + WIDTH'(1);

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk    (clk),
    .resetB (resetB),
    .push   (push),
    .pop    (pop),
    .din    (pc_inc),
    .top    (top),
    .sp     (sp),
    .full   (stackFull),
    .empty  (stackEmpty)
  );

  // Opcode decode: next PC, stack gating and fault detection.
  always_comb begin
    pc_nxt    = pc;
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = 1'b0;
    case (op)
      OP_INC:    pc_nxt = pc_inc;
      OP_JUMP:   pc_nxt = dbus;
      OP_BRANCH: pc_nxt = branch_target(pc, dbus);
      OP_CALL: begin
        if (stackFull) begin
          fault_set = 1'b1;
        end else begin
          push   = resetB;
          pc_nxt = dbus;
        end
      end
      OP_RET: begin
        if (stackEmpty) begin
          fault_set = 1'b1;
        end else begin
          pop    = resetB;
          pc_nxt = top;
        end
      end
      default: pc_nxt = pc;
    endcase
  end

  // PC and sticky fault registers; reset overrides any opcode.
  always_ff @(posedge clk) begin
    if (!resetB) begin
      pc    <= RESET_VECTOR;
      fault <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (fault_set) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// Self-checking bench for pc_return_stack: directed test-plan steps followed by
// random operations, all checked against a queue-based reference model.
module tb_pc_return_stack;
  import pc_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RV = 8'h00;
  localparam int SP_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             resetB = 1'b0;
  logic [OP_W-1:0]  op = '0;
  logic [WIDTH-1:0] dbus = '0;
  logic [WIDTH-1:0] pc;
  logic [SP_W-1:0]  sp;
  logic             stackEmpty;
  logic             stackFull;
  logic             fault;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_pc = 0;
  int m_fault = 0;
  int m_stack[$];

  pc_return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk        (clk),
    .resetB     (resetB),
    .op         (op),
    .dbus       (dbus),
    .pc         (pc),
    .sp         (sp),
    .stackEmpty (stackEmpty),
    .stackFull  (stackFull),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec-level behaviour of one clock edge.
  task automatic model_step(input int o, input int d, input bit rst_n);
    if (!rst_n) begin
      m_pc = int'(RV);
      m_stack.delete();
      m_fault = 0;
    end else begin
      case (o)
        1: m_pc = (m_pc + 1) % 256;
        2: m_pc = d;
        3: m_pc = (m_pc + ((d >= 128) ? d - 256 : d) + 256) % 256;
        4: if (m_stack.size() == DEPTH) m_fault = 1;
           else begin
             m_stack.push_back((m_pc + 1) % 256);
             m_pc = d;
           end
        5: if (m_stack.size() == 0) m_fault = 1;
           else m_pc = m_stack.pop_back();
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    int'(pc),         m_pc);
    check({tag, ".sp"},    int'(sp),         m_stack.size());
    check({tag, ".empty"}, int'(stackEmpty), int'(m_stack.size() == 0));
    check({tag, ".full"},  int'(stackFull),  int'(m_stack.size() == DEPTH));
    check({tag, ".fault"}, int'(fault),      m_fault);
  endtask

  task automatic step(input string tag, input int o, input int d, input bit rst_n);
    op     = OP_W'(o);
    dbus   = WIDTH'(d);
    resetB = rst_n;
    @(posedge clk);
    #1;
    model_step(o, d, rst_n);
    check_all(tag);
    resetB = 1'b1;
  endtask

  initial begin
    int o, d;
    bit r;

    // Reset and INC wrap
    step("reset", 1, 0, 1'b0);
    check("reset.pc_const", int'(pc), 0);
    for (int i = 1; i <= 257; i++) begin
      step("inc", 1, $urandom_range(0, 255), 1'b1);
      if (i == 255) check("inc255", int'(pc), 8'hFF);
      if (i == 256) check("inc256", int'(pc), 8'h00);
    end
    check("inc257", int'(pc), 8'h01);
    check("inc.fault", int'(fault), 0);

    // JUMP and signed BRANCH
    step("jmp10", 2, 8'h10, 1'b1);
    step("jmp80", 2, 8'h80, 1'b1);
    check("jmp80_const", int'(pc), 8'h80);
    step("brFE", 3, 8'hFE, 1'b1);
    check("brFE_const", int'(pc), 8'h7E);
    step("br90", 3, 8'h90, 1'b1);
    check("br90_const", int'(pc), 8'h0E);

    // Nested CALL/RET
    step("jmp05", 2, 8'h05, 1'b1);
    step("call40", 4, 8'h40, 1'b1);
    check("call40_const", int'(pc), 8'h40);
    step("call60", 4, 8'h60, 1'b1);
    check("call60_sp", int'(sp), 2);
    step("ret1", 5, 0, 1'b1);
    check("ret1_const", int'(pc), 8'h41);
    step("ret2", 5, 0, 1'b1);
    check("ret2_const", int'(pc), 8'h06);
    check("nest.fault", int'(fault), 0);

    // Overflow then LIFO unwind
    for (int i = 0; i < 4; i++) step("fill", 4, 8'h20 + 8'h10 * i, 1'b1);
    check("fill.full", int'(stackFull), 1);
    step("ovf", 4, 8'h99, 1'b1);
    check("ovf.pc_const", int'(pc), 8'h50);
    check("ovf.fault_const", int'(fault), 1);
    step("unw1", 5, 0, 1'b1);
    check("unw1_const", int'(pc), 8'h41);
    step("unw2", 5, 0, 1'b1);
    check("unw2_const", int'(pc), 8'h31);
    step("unw3", 5, 0, 1'b1);
    check("unw3_const", int'(pc), 8'h21);
    step("unw4", 5, 0, 1'b1);
    check("unw4_const", int'(pc), 8'h07);

    // Underflow and stickiness
    step("rst2", 0, 0, 1'b0);
    step("udf", 5, 0, 1'b1);
    check("udf.fault_const", int'(fault), 1);
    step("callafter", 4, 8'hA0, 1'b1);
    check("callafter.sp_const", int'(sp), 1);
    step("rst3", 0, 0, 1'b0);
    check("rst3.fault_const", int'(fault), 0);

    // Reserved ops and reset colliding with CALL
    step("jmp33", 2, 8'h33, 1'b1);
    step("op6", 6, 8'h12, 1'b1);
    step("op7", 7, 8'h34, 1'b1);
    check("op7.pc_const", int'(pc), 8'h33);
    step("call_pre", 4, 8'h70, 1'b1);
    step("rst_call", 4, 8'h88, 1'b0);
    check("rst_call.sp_const", int'(sp), 0);
    step("ret_after_rst", 5, 0, 1'b1);

    // Random operations
    for (int i = 0; i < 600; i++) begin
      o = int'($urandom_range(0, 7));
      if (o == 4 || o == 5) o = (($urandom_range(0, 1)) != 0) ? 4 : 5;
      d = int'($urandom_range(0, 255));
      r = ($urandom_range(0, 49) != 0);
      step("rand", o, d, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_return_stack.md
# pc_return_stack

Parametrised program counter with an integrated return-address stack; the next-generation sequencer for the CPU datapath. Adds relative branches, CALL/RET and fault reporting on top of the plain increment/load/clear counter. It sits between instruction decode, which supplies `op`, and the data bus, which supplies jump targets and branch offsets. It drives the fetch address.

## Interface
Parameters:
- `WIDTH`, 8, PC and data-bus width in bits (≥4).
- `DEPTH`, 4, return-stack entries (≥1).
- `RESET_VECTOR`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `resetB`  in  1  synchronous, active-low reset.
- `op`  in  3  operation code, sampled each rising edge.
- `dbus`  in  WIDTH  jump target or two's-complement branch offset.
- `pc`  out  WIDTH  current program counter (registered).
- `sp`  out  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH (registered).
- `stackEmpty`  out  1  `sp == 0`.
- `stackFull`  out  1  `sp == DEPTH`.
- `fault`  out  1  sticky stack overflow/underflow flag (registered).

## Operation
Opcodes:
- 0 HOLD: no state change.
- 1 INC: `pc <= pc + 1`.
- 2 JUMP: `pc <= dbus`.
- 3 BRANCH: `pc <= pc + dbus`, with `dbus` treated as signed WIDTH-bit.
- 4 CALL: push `pc + 1`, then `pc <= dbus`, `sp <= sp + 1`.
- 5 RET: `pc <=` top entry, `sp <= sp - 1`.
- 6, 7: reserved, behave as HOLD.

Arithmetic and boundary rules:
- All PC arithmetic is modulo 2^WIDTH. INC at all-ones gives 0. BRANCH wraps both ways.
- The pushed return address `pc + 1` also wraps modulo 2^WIDTH.
- CALL when `stackFull`:
  - no push; `pc` and `sp` unchanged; `fault <= 1`.
- RET when `stackEmpty`:
  - `pc` and `sp` unchanged; `fault <= 1`.
- `fault` is sticky. Only reset clears it. It does not block later operations.
- Stack is strictly LIFO. Only the top entry is readable.

Reset:
- `resetB` low at a rising edge sets `pc = RESET_VECTOR`, `sp = 0` and `fault = 0`. This overrides `op`.
- Stack storage is not cleared. Contents are unobservable once `sp = 0`.
- Reset asserted mid-sequence (e.g. between a CALL and its RET) discards all pending return addresses.

## Timing
- Latency is one cycle. An `op`/`dbus` pair sampled at edge N is reflected on `pc`, `sp` and `fault` after edge N.
- No combinational path from `op` or `dbus` to any output.
- `stackEmpty` and `stackFull` decode only from registered `sp`.
- Back-to-back CALL/RET every cycle is supported.
  - After a CALL at edge N, a RET at edge N+1 returns the value pushed at N.
- No handshake: decode must hold `op` stable across the setup window. `dbus` is don't-care for HOLD, INC and RET.

## Structure
- Shared package `pc_pkg` holds:
  - the `pc_op_e` enum (HOLD, INC, JUMP, BRANCH, CALL, RET);
  - the `OP_W = 3` constant.
- One sub-module, `return_stack`:
  - parameters WIDTH and DEPTH;
  - ports: synchronous push/pop, push data, top-of-stack output, `sp`, full, empty.
  - Overflow/underflow gating and fault logic live in the top level, not in `return_stack`.
- Top level holds the PC register, next-PC mux and adder, and the fault register.

## Test plan
- Reset and INC wrap (WIDTH=8): `resetB` low, then INC ×257 → `pc` = 0x00 after reset, 0xFF after 255 INCs, 0x00 after 256, 0x01 after 257; `fault` stays 0.
- JUMP and signed BRANCH: from pc=0x10, JUMP 0x80 → 0x80. Then BRANCH 0xFE → 0x7E. Then BRANCH 0x90 → 0x0E (wraps).
- Nested CALL/RET (DEPTH=4):
  - pc=0x05, CALL 0x40 → pc=0x40, sp=1;
  - then CALL 0x60 → pc=0x60, sp=2;
  - RET → pc=0x41, sp=1; RET → pc=0x06, sp=0;
  - `fault` stays 0 throughout.
- Overflow: 4 CALLs fill the stack (`stackFull`=1). A 5th CALL to 0x99 leaves pc and sp unchanged and sets `fault`=1. Four RETs then return correct addresses in LIFO order.
- Underflow and stickiness: RET with sp=0 → pc unchanged, `fault`=1. A following CALL succeeds with `fault` still 1. `resetB` low → `fault`=0, sp=0, pc=RESET_VECTOR.
- Reserved ops and reset mid-operation:
  - op 6/7 → no change;
  - reset asserted together with CALL → CALL ignored, post-reset state as specified.
